updown_sweep_ctrl: RTL

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

---
 rtl/updown_sweep_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller for an external up/down counter: clears it, seeks to the
// lower bound, then bounces between the latched limits for a requested number of sweeps.
module updown_sweep_ctrl #(
    parameter int WIDTH   = 5,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo_limit,
    input  logic [WIDTH-1:0]   hi_limit,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [WIDTH-1:0]   cnt_in,
    output logic               cnt_reset,
    output logic               cnt_en,
    output logic               cnt_ctrl,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SEEK  = 3'd2,
        UP    = 3'd3,
        DOWN  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [SWEEP_W-1:0] num_q;
    logic [SWEEP_W-1:0] sweep_inc;
    logic               start_ok;
    logic               at_lo;
    logic               at_hi;
    logic               accept;
    logic               reject;
    logic               sweep_step;

    assign start_ok  = (lo_limit < hi_limit) && (num_sweeps != '0);
    assign at_lo     = (cnt_in == lo_q);
    assign at_hi     = (cnt_in == hi_q);
    assign sweep_inc = sweep_cnt + SWEEP_W'(1);

    // Enable is purely combinational on the live counter value, so the counter
    // stops on the exact edge it reaches a limit instead of one step later.
    always_comb begin
        state_next = state;
        cnt_reset  = 1'b0;
        cnt_en     = 1'b0;
        cnt_ctrl   = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        sweep_step = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        accept     = 1'b1;
                        state_next = CLEAR;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            CLEAR: begin
                cnt_reset  = 1'b1;
                state_next = SEEK;
            end
            SEEK: begin
                cnt_en = !at_lo;
                if (at_lo) state_next = UP;
            end
            UP: begin
                cnt_en = !at_hi;
                if (at_hi) state_next = DOWN;
            end
            DOWN: begin
                cnt_ctrl = 1'b1;
                cnt_en   = !at_lo;
                if (at_lo) begin
                    sweep_step = 1'b1;
                    state_next = (sweep_inc == num_q) ? DONE : UP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Abort wins over everything, including the final sweep count update.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            sweep_step = 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            num_q     <= '0;
            sweep_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            err   <= reject;
            if (accept) begin
                lo_q      <= lo_limit;
                hi_q      <= hi_limit;
                num_q     <= num_sweeps;
                sweep_cnt <= '0;
            end else if (sweep_step) begin
                sweep_cnt <= sweep_inc;
            end
        end
    end

endmodule
